axi4_lite_master: RTL and testbench

- AXI4-Lite initiator that turns single-beat commands from an internal controller into AXI4-Lite read/write transactions.
- Used by on-chip sequencers to reach AXI4-Lite register slaves, including the project's own slave-side register bridge.
- One transaction outstanding at a time; the response is returned on a valid/ready response port.

---
 rtl/axi4_lite_pkg.sv | 26 ++
 rtl/axi4_lite_master.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
//   Shared definitions for the AXI4-Lite initiator:
//   - AXI response codes (BRESP/RRESP encodings)
//   - 3-bit FSM state encoding used by axi4_lite_master
//   - width of the optional error counter
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    READ  = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//   Converts single-beat commands from an internal controller into AXI4-Lite
//   read/write transactions, one outstanding at a time, and returns the result
//   on a valid/ready response port.
//
// Ports
//   s_axi_clk, s_axi_rst_n      clock, asynchronous active-low reset
//   cmd_*                       command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                       response out (valid/ready, rdata, resp, write echo)
//   m_axi_*                     AXI4-Lite master channels AW, W, B, AR, R
//                               (awprot/arprot tied to 3'b000)
//
// Optional feature (macro AXI4_LITE_MASTER_ERR_CNT_EN)
//   err_clr   in   synchronous clear of the error counter (wins over an error)
//   err_count out  saturating count of non-OKAY B/R handshakes
// -----------------------------------------------------------------------------
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        s_axi_clk,
  input  logic                        s_axi_rst_n,
  // command port
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_write,
  // AXI4-Lite master
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
  ,
  input  logic                        err_clr,
  output logic [ERR_CNT_WIDTH-1:0]    err_count
`endif
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic                      write_q, write_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;

  // Handshakes only ever use the registered valid/ready, so a slave ready
  // never reaches a master valid through combinational logic.
  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = awvalid_q && m_axi_awready;
  assign w_fire  = wvalid_q  && m_axi_wready;
  assign b_fire  = bready_q  && m_axi_bvalid;
  assign ar_fire = arvalid_q && m_axi_arready;
  assign r_fire  = rready_q  && m_axi_rvalid;

  always_comb begin
    // NOTE: every _d gets its hold value first; any path that forgets an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          rdata_d = '0;          // writes report zero read data
          resp_d  = RESP_OKAY;
          if (cmd_write) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently, in either order or together.
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (b_fire) begin
          bready_d    = 1'b0;
          resp_d      = m_axi_bresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      READ: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (r_fire) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi_rdata;
          resp_d      = m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    // NOTE: payload registers are reset too, because every AXI and response
    // output must read zero while in reset.
    if (!s_axi_rst_n) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_write     = write_q;

`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_count_q;
  logic                     err_event;

  assign err_event = (b_fire && (m_axi_bresp != RESP_OKAY)) ||
                     (r_fire && (m_axi_rresp != RESP_OKAY));

  always_ff @(posedge s_axi_clk or negedge s_axi_rst_n) begin
    if (!s_axi_rst_n) begin
      err_count_q <= '0;
    end else if (err_clr) begin
      err_count_q <= '0;                    // clear wins over a same-cycle error
    end else if (err_event && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;    // saturates at all-ones
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
//   Self-checking bench for axi4_lite_master. A cycle-based AXI4-Lite slave
//   with per-channel wait counts answers the DUT; expected responses are
//   queued when a command is accepted and compared when the response
//   handshake occurs. Inputs are driven 1 time unit after the rising edge,
//   outputs are sampled on the falling edge.
//   Optional section for AXI4_LITE_MASTER_ERR_CNT_EN exercises err_count.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp, rresp;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
  logic          err_clr;
  logic [15:0]   err_count;
  logic          clr_on_r;
`endif

  axi4_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .s_axi_clk    (clk),
    .s_axi_rst_n  (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_write    (rsp_write),
    .m_axi_awaddr (awaddr),
    .m_axi_awprot (awprot),
    .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata  (wdata),
    .m_axi_wstrb  (wstrb),
    .m_axi_wvalid (wvalid),
    .m_axi_wready (wready),
    .m_axi_bresp  (bresp),
    .m_axi_bvalid (bvalid),
    .m_axi_bready (bready),
    .m_axi_araddr (araddr),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready)
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    ,
    .err_clr      (err_clr),
    .err_count    (err_count)
`endif
  );

  // ---------------------------------------------------------------- checking
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];

  // ------------------------------------------------------------ slave model
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  logic [31:0] rdata_cfg = '0;

  int   aw_wait, w_wait, b_wait, ar_wait, r_wait;
  logic got_aw, got_w, got_ar;
  logic aw_fire_s, w_fire_s, b_fire_s, ar_fire_s, r_fire_s;   // written by monitor

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    got_aw = 0; got_w = 0; got_ar = 0;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    err_clr = 0;
`endif
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
      end else begin
        if (awvalid && !awready) begin
          if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
        end else begin awready = 0; aw_wait = 0; end
        if (wvalid && !wready) begin
          if (w_wait >= w_delay) wready = 1; else w_wait++;
        end else begin wready = 0; w_wait = 0; end
        if (arvalid && !arready) begin
          if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
        end else begin arready = 0; ar_wait = 0; end

        if (aw_fire_s) got_aw = 1;
        if (w_fire_s)  got_w  = 1;
        if (b_fire_s) begin
          bvalid = 0; bresp = 0;
        end else if (got_aw && got_w && !bvalid) begin
          if (b_wait >= b_delay) begin
            bvalid = 1; bresp = bresp_cfg; got_aw = 0; got_w = 0; b_wait = 0;
          end else b_wait++;
        end

        if (ar_fire_s) got_ar = 1;
        if (r_fire_s) begin
          rvalid = 0; rdata = 0; rresp = 0;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
          err_clr = 0;
`endif
        end else if (got_ar && !rvalid) begin
          if (r_wait >= r_delay) begin
            rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; got_ar = 0; r_wait = 0;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
            if (clr_on_r) err_clr = 1;
`endif
          end else r_wait++;
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  always @(posedge clk) cyc++;

  int          aw_cycles = 0, w_cycles = 0, ar_cycles = 0, rsp_count = 0, viol = 0;
  int          rsp_first_cyc = 0;
  logic [31:0] seen_awaddr, seen_wdata, seen_wstrb, seen_araddr;
  logic        p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
  logic        p_rsp_valid, p_rsp_ready, p_rsp_write;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata, p_rsp_rdata;
  logic [SW-1:0] p_wstrb;
  logic [1:0]    p_rsp_resp;
  exp_t          e;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_fire_s = 0; w_fire_s = 0; b_fire_s = 0; ar_fire_s = 0; r_fire_s = 0;
      p_awvalid = 0; p_awready = 0; p_wvalid = 0; p_wready = 0;
      p_arvalid = 0; p_arready = 0; p_rsp_valid = 0; p_rsp_ready = 0;
    end else begin
      aw_fire_s = awvalid && awready;
      w_fire_s  = wvalid && wready;
      b_fire_s  = bvalid && bready;
      ar_fire_s = arvalid && arready;
      r_fire_s  = rvalid && rready;
      if (awvalid) aw_cycles++;
      if (wvalid)  w_cycles++;
      if (arvalid) ar_cycles++;
      if (awvalid && !p_awvalid) seen_awaddr = 32'(awaddr);
      if (wvalid && !p_wvalid) begin seen_wdata = wdata; seen_wstrb = 32'(wstrb); end
      if (arvalid && !p_arvalid) seen_araddr = 32'(araddr);
      // valid held and payload stable until handshake
      if (p_awvalid && !p_awready && (!awvalid || awaddr != p_awaddr)) viol++;
      if (p_wvalid && !p_wready && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol++;
      if (p_arvalid && !p_arready && (!arvalid || araddr != p_araddr)) viol++;
      if (p_rsp_valid && !p_rsp_ready &&
          (!rsp_valid || rsp_rdata != p_rsp_rdata || rsp_resp != p_rsp_resp ||
           rsp_write != p_rsp_write)) viol++;
      if (bready && (awvalid || wvalid)) viol++;
      if (awprot != 3'b000 || arprot != 3'b000) viol++;
      if (rsp_valid && !p_rsp_valid) rsp_first_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        check("rsp_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp",  32'(rsp_resp), 32'(e.resp));
        end
      end
      p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
      p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wstrb = wstrb;
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
      p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready;
      p_rsp_rdata = rsp_rdata; p_rsp_resp = rsp_resp; p_rsp_write = rsp_write;
    end
  end

  // ------------------------------------------------------------- stimulus
  int accept_cyc = 0;

  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [SW-1:0] ws, input logic [31:0] erd, input logic [1:0] eresp);
    exp_t x;
    int   n = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 200);
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    accept_cyc = cyc + 1;
    x.write = wr;
    x.rdata = wr ? 32'd0 : erd;
    x.resp  = eresp;
    exp_q.push_back(x);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 300) begin @(negedge clk); n++; end
    check("rsp_arrived", 32'(rsp_count), 32'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int base_aw, base_w, base_ar, base_rsp, hold_bad, n;

  initial begin
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    clr_on_r = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("rst_addr",   32'({awaddr, araddr}), 32'd0);
    check("rst_wdata",  {wdata[31:4], wstrb}, 32'd0);
    check("rst_rsp",    {rsp_rdata[29:0], rsp_resp} ^ 32'(rsp_write), 32'd0);
    rst_n = 1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // zero-wait write: 3-cycle latency, payload on AW/W
    base_aw = aw_cycles; base_w = w_cycles;
    send(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'd0, RESP_OKAY);
    wait_rsp(1);
    check("wr_awaddr",  seen_awaddr, 32'h010);
    check("wr_wdata",   seen_wdata,  32'hDEADBEEF);
    check("wr_wstrb",   seen_wstrb,  32'hF);
    check("wr_latency", 32'(rsp_first_cyc - accept_cyc + 1), 32'd3);
    check("wr_aw_cyc",  32'(aw_cycles - base_aw), 32'd1);
    check("wr_w_cyc",   32'(w_cycles - base_w), 32'd1);

    // zero-wait read latency
    rdata_cfg = 32'hA5A5_0001;
    send(1'b0, 12'h004, 32'h0, 4'h0, 32'hA5A5_0001, RESP_OKAY);
    wait_rsp(2);
    check("rd_latency", 32'(rsp_first_cyc - accept_cyc + 1), 32'd3);

    // read with AR stalled 4 cycles
    ar_delay = 4; rdata_cfg = 32'h12345678; base_ar = ar_cycles;
    send(1'b0, 12'h020, 32'h0, 4'h0, 32'h12345678, RESP_OKAY);
    wait_rsp(3);
    ar_delay = 0;
    check("rd_araddr", seen_araddr, 32'h020);
    check("rd_ar_cyc", 32'(ar_cycles - base_ar), 32'd5);

    // AW late by 5 cycles, W immediate
    aw_delay = 5; base_aw = aw_cycles; base_w = w_cycles;
    send(1'b1, 12'h030, 32'h0BAD_F00D, 4'h3, 32'd0, RESP_OKAY);
    wait_rsp(4);
    repeat (5) @(posedge clk);
    #1;
    aw_delay = 0;
    check("skew_aw_cyc", 32'(aw_cycles - base_aw), 32'd6);
    check("skew_w_cyc",  32'(w_cycles - base_w), 32'd1);
    check("skew_one_rsp", 32'(rsp_count), 32'd4);

    // W late by 3 cycles, AW immediate
    w_delay = 3; b_delay = 2; base_aw = aw_cycles; base_w = w_cycles;
    send(1'b1, 12'h034, 32'h1357_9BDF, 4'h8, 32'd0, RESP_OKAY);
    wait_rsp(5);
    w_delay = 0; b_delay = 0;
    check("wskew_aw_cyc", 32'(aw_cycles - base_aw), 32'd1);
    check("wskew_w_cyc",  32'(w_cycles - base_w), 32'd4);

    // SLVERR write with response back-pressure
    bresp_cfg = RESP_SLVERR; rsp_ready = 0;
    send(1'b1, 12'h040, 32'hFFFF_0000, 4'hC, 32'd0, RESP_SLVERR);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    hold_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready || !rsp_valid) hold_bad++;
    end
    check("bp_hold", 32'(hold_bad), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1; bresp_cfg = RESP_OKAY;
    wait_rsp(6);
    @(negedge clk);
    check("bp_cmd_ready_after", 32'(cmd_ready), 32'd1);

    // DECERR read passed through with R wait states
    rresp_cfg = RESP_DECERR; r_delay = 2; rdata_cfg = 32'h0000_BEEF;
    send(1'b0, 12'h050, 32'h0, 4'h0, 32'h0000_BEEF, RESP_DECERR);
    wait_rsp(7);
    rresp_cfg = RESP_OKAY; r_delay = 0;

    // reset while arvalid is high
    ar_delay = 20;
    send(1'b0, 12'h060, 32'h0, 4'h0, 32'h0, RESP_OKAY);
    n = 0;
    while (!arvalid && n < 50) begin @(negedge clk); n++; end
    check("mid_arvalid", 32'(arvalid), 32'd1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("mid_rst_outs", 32'({arvalid, rready, rsp_valid}), 32'd0);
    exp_q.delete();
    base_rsp = rsp_count;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    ar_delay = 0;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", 32'(rsp_count), 32'(base_rsp));
    rdata_cfg = 32'hCAFE_F00D;
    send(1'b0, 12'h024, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_OKAY);
    wait_rsp(base_rsp + 1);

`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    check("err_cnt_start", 32'(err_count), 32'd0);
    rresp_cfg = RESP_SLVERR;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 12'h070, 32'h0, 4'h0, rdata_cfg, RESP_SLVERR);
      wait_rsp(base_rsp + 2 + i);
    end
    check("err_cnt_3", 32'(err_count), 32'd3);
    clr_on_r = 1;
    send(1'b0, 12'h074, 32'h0, 4'h0, rdata_cfg, RESP_SLVERR);
    wait_rsp(base_rsp + 5);
    clr_on_r = 0;
    check("err_cnt_clr_wins", 32'(err_count), 32'd0);
    send(1'b0, 12'h078, 32'h0, 4'h0, rdata_cfg, RESP_SLVERR);
    wait_rsp(base_rsp + 6);
    check("err_cnt_resume", 32'(err_count), 32'd1);
    rresp_cfg = RESP_OKAY;
`endif

    check("protocol_violations", 32'(viol), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
